if_fetch_stage: RTL

- Instruction-fetch stage that sits directly upstream of the instruction memory in the CPU datapath.
- Holds the program counter and drives the fetch address to instruction memory.
- Captures the returned word, with its PC and PC+4, into an IF/ID pipeline register for the decoder.
- Supports stall, branch/jump redirect with flush, and an out-of-range fetch guard.

---
 rtl/if_fetch_stage_if.sv | 27 ++
 rtl/if_fetch_stage.sv | 86 ++++++++
 2 files changed

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: control in, instruction-memory port, and the IF/ID register outputs.
// master = the fetch stage; slave = hazard unit, instruction memory and decoder side.
interface if_fetch_stage_if;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic        ifid_valid_o;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_pc_plus4_o;
  logic [31:0] ifid_instr_o;
  logic        oob_o;
  logic [31:0] fetch_cnt_o;

  modport master (
    input  stall_i, redirect_i, redirect_pc_i, imem_instr_i,
    output imem_addr_o, ifid_valid_o, ifid_pc_o, ifid_pc_plus4_o,
           ifid_instr_o, oob_o, fetch_cnt_o
  );

  modport slave (
    output stall_i, redirect_i, redirect_pc_i, imem_instr_i,
    input  imem_addr_o, ifid_valid_o, ifid_pc_o, ifid_pc_plus4_o,
           ifid_instr_o, oob_o, fetch_cnt_o
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID capture, redirect/flush, stall, out-of-range guard.
// Optional fetch counter enabled by macro FETCH_PERF_CNT_EN.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 32
) (
  input logic              clk_i,
  input logic              rst_i,
  if_fetch_stage_if.master bus
);

  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_DEPTH * 4);

  logic [31:0] pc_q;
  logic        valid_q;
  logic [31:0] ifid_pc_q;
  logic [31:0] ifid_pc_plus4_q;
  logic [31:0] ifid_instr_q;
  logic        oob_q;

  logic [31:0] pc_plus4;
  logic        in_range;
  logic [31:0] fetch_word;
  logic        capture;

  // Stage semantics: redirect flushes and wins over stall; stall freezes PC and IF/ID;
  // otherwise every edge captures one word and ifid_valid_o marks it as real.
  always_comb begin
    pc_plus4   = pc_q + 32'd4;
    in_range   = (pc_q < IMEM_BYTES);
    fetch_word = in_range ? bus.imem_instr_i : 32'h0000_0000;
    capture    = !bus.redirect_i && !bus.stall_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q            <= RESET_PC;
      valid_q         <= 1'b0;
      ifid_pc_q       <= 32'h0;
      ifid_pc_plus4_q <= 32'h0;
      ifid_instr_q    <= 32'h0;
      oob_q           <= 1'b0;
    end else if (bus.redirect_i) begin
      pc_q            <= {bus.redirect_pc_i[31:2], 2'b00};
      valid_q         <= 1'b0;
      ifid_pc_q       <= 32'h0;
      ifid_pc_plus4_q <= 32'h0;
      ifid_instr_q    <= 32'h0;
    end else if (!bus.stall_i) begin
      pc_q            <= pc_plus4;
      valid_q         <= 1'b1;
      ifid_pc_q       <= pc_q;
      ifid_pc_plus4_q <= pc_plus4;
      ifid_instr_q    <= fetch_word;
      if (!in_range) begin
        oob_q <= 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= 32'h0;
    end else if (capture) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign bus.fetch_cnt_o = cnt_q;
`else
  logic unused_capture;
  assign unused_capture  = capture;
  assign bus.fetch_cnt_o = 32'h0;
`endif

  assign bus.imem_addr_o     = pc_q;
  assign bus.ifid_valid_o    = valid_q;
  assign bus.ifid_pc_o       = ifid_pc_q;
  assign bus.ifid_pc_plus4_o = ifid_pc_plus4_q;
  assign bus.ifid_instr_o    = ifid_instr_q;
  assign bus.oob_o           = oob_q;

endmodule
